// File: rtl/alu_uart_ctrl_if.sv
// Bus bundle between the frame sequencer and its UART RX/TX and ALU neighbours.
// slave = sequencer side, master = environment side.
interface alu_uart_ctrl_if #(
  parameter int unsigned NB_DATA   = 8,
  parameter int unsigned NB_OPCODE = 6
);
  logic [NB_DATA-1:0]   rx_data;
  logic                 rx_done;
  logic                 tx_done;
  logic [NB_DATA-1:0]   alu_result;
  logic [NB_DATA-1:0]   dato_a;
  logic [NB_DATA-1:0]   dato_b;
  logic [NB_OPCODE-1:0] opcode;
  logic [NB_DATA-1:0]   tx_data;
  logic                 tx_start;
  logic                 busy;
  logic                 timeout_err;
  logic                 rx_overrun;

  modport slave (
    input  rx_data, rx_done, tx_done, alu_result,
    output dato_a, dato_b, opcode, tx_data, tx_start, busy, timeout_err, rx_overrun
  );

  modport master (
    output rx_data, rx_done, tx_done, alu_result,
    input  dato_a, dato_b, opcode, tx_data, tx_start, busy, timeout_err, rx_overrun
  );
endinterface

// File: rtl/alu_uart_ctrl.sv
// Frame sequencer: collects A, B, opcode bytes from UART RX, drives the ALU,
// and hands the result to UART TX with an inter-byte timeout and overrun flag.
module alu_uart_ctrl #(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OPCODE      = 6,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned NB_TIMEOUT     = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_uart_ctrl_if.slave  bus
);

  localparam logic [NB_TIMEOUT-1:0] TO_LAST =
    NB_TIMEOUT'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX
  } state_t;

  state_t                  r_state, w_state_next;
  logic [NB_TIMEOUT-1:0]   r_cnt, w_cnt_next;
  logic [NB_DATA-1:0]      r_dato_a, r_dato_b, r_tx_data;
  logic [NB_OPCODE-1:0]    r_opcode;
  logic                    r_tx_start, r_busy, r_timeout_err, r_rx_overrun;
  logic                    w_ld_a, w_ld_b, w_ld_op, w_ld_tx, w_timeout, w_overrun;
  logic                    w_to_hit;

  assign w_to_hit = TO_EN && (r_cnt == TO_LAST) && !bus.rx_done;

  // State and timeout counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_A;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and load-enable decode
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ld_a       = 1'b0;
    w_ld_b       = 1'b0;
    w_ld_op      = 1'b0;
    w_ld_tx      = 1'b0;
    w_timeout    = 1'b0;
    w_overrun    = 1'b0;
    case (r_state)
      WAIT_A: begin
        if (bus.rx_done) begin
          w_ld_a       = 1'b1;
          w_state_next = WAIT_B;
          w_cnt_next   = '0;
        end
      end
      WAIT_B, WAIT_OP: begin
        if (bus.rx_done) begin
          w_ld_b       = (r_state == WAIT_B);
          w_ld_op      = (r_state == WAIT_OP);
          w_state_next = (r_state == WAIT_B) ? WAIT_OP : EXEC;
          w_cnt_next   = '0;
        end else if (w_to_hit) begin
          w_timeout    = 1'b1;
          w_state_next = WAIT_A;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + NB_TIMEOUT'(1);
        end
      end
      EXEC: begin
        w_ld_tx      = 1'b1;
        w_overrun    = bus.rx_done;
        w_state_next = SEND;
      end
      SEND: begin
        w_overrun    = bus.rx_done;
        w_state_next = WAIT_TX;
      end
      WAIT_TX: begin
        w_overrun = bus.rx_done;
        if (bus.tx_done) w_state_next = WAIT_A;
      end
      default: w_state_next = WAIT_A;
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dato_a      <= '0;
      r_dato_b      <= '0;
      r_opcode      <= '0;
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_rx_overrun  <= 1'b0;
    end else begin
      if (w_ld_a)  r_dato_a  <= bus.rx_data;
      if (w_ld_b)  r_dato_b  <= bus.rx_data;
      if (w_ld_op) r_opcode  <= bus.rx_data[NB_OPCODE-1:0];
      if (w_ld_tx) r_tx_data <= bus.alu_result;
      r_tx_start    <= (w_state_next == SEND);
      r_busy        <= (w_state_next != WAIT_A);
      r_timeout_err <= w_timeout;
      if (w_overrun) r_rx_overrun <= 1'b1;
    end
  end

  assign bus.dato_a      = r_dato_a;
  assign bus.dato_b      = r_dato_b;
  assign bus.opcode      = r_opcode;
  assign bus.tx_data     = r_tx_data;
  assign bus.tx_start    = r_tx_start;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;
  assign bus.rx_overrun  = r_rx_overrun;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl: frames, timeout boundary, overrun,
// mid-frame reset and opcode masking, against hand-computed results.
module tb_alu_uart_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_txs   = 0;
  int   n_to    = 0;

  alu_uart_ctrl_if #(.NB_DATA(8), .NB_OPCODE(6)) bus ();

  alu_uart_ctrl #(
    .NB_DATA(8), .NB_OPCODE(6), .TIMEOUT_CYCLES(16), .NB_TIMEOUT(20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference ALU sitting on the DUT operand outputs
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return $signed(a) >>> b;
      6'h02:   return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  assign bus.alu_result = alu_model(bus.dato_a, bus.dato_b, bus.opcode);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.tx_start)    n_txs <= n_txs + 1;
    if (bus.timeout_err) n_to  <= n_to + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
  endtask

  // Full frame: gap_b idles before byte B, ovr injects a byte during WAIT_TX
  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [5:0] exp_op,
                           input logic [7:0] exp_res, input int gap_b, input bit ovr);
    int txs0;
    txs0 = n_txs;
    send_byte(a);
    check({tag, "_busy_after_a"}, 32'(bus.busy), 32'd1);
    repeat (gap_b) @(negedge clk);
    send_byte(b);
    send_byte(op);
    check({tag, "_exec_no_start"}, 32'(bus.tx_start), 32'd0);
    check({tag, "_dato_a"}, 32'(bus.dato_a), 32'(a));
    check({tag, "_dato_b"}, 32'(bus.dato_b), 32'(b));
    check({tag, "_opcode"}, 32'(bus.opcode), 32'(exp_op));
    @(negedge clk);
    check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd1);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'(exp_res));
    @(negedge clk);
    check({tag, "_start_fell"}, 32'(bus.tx_start), 32'd0);
    check({tag, "_one_start"}, 32'(n_txs - txs0), 32'd1);
    if (ovr) begin
      send_byte(8'hAA);
      check({tag, "_overrun_set"}, 32'(bus.rx_overrun), 32'd1);
      check({tag, "_ovr_dato_a"}, 32'(bus.dato_a), 32'(a));
      check({tag, "_ovr_still_busy"}, 32'(bus.busy), 32'd1);
    end
    pulse_tx_done();
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_tx_data_held"}, 32'(bus.tx_data), 32'(exp_res));
  endtask

  initial begin
    int txs0;
    rst_n       = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dato_a",   32'(bus.dato_a), 32'd0);
    check("rst_dato_b",   32'(bus.dato_b), 32'd0);
    check("rst_opcode",   32'(bus.opcode), 32'd0);
    check("rst_tx_data",  32'(bus.tx_data), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_busy",     32'(bus.busy), 32'd0);
    check("rst_timeout",  32'(bus.timeout_err), 32'd0);
    check("rst_overrun",  32'(bus.rx_overrun), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame("add", 8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 0, 1'b0);
    run_frame("sub", 8'h03, 8'h05, 8'h22, 6'h22, 8'hFE, 0, 1'b0);

    // Lone byte A: timeout 16 cycles after entering WAIT_B
    send_byte(8'h10);
    repeat (15) @(negedge clk);
    check("to_not_yet", 32'(bus.timeout_err), 32'd0);
    check("to_busy_pre", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("to_pulse", 32'(bus.timeout_err), 32'd1);
    check("to_busy_post", 32'(bus.busy), 32'd0);
    check("to_dato_a_kept", 32'(bus.dato_a), 32'h10);
    @(negedge clk);
    check("to_pulse_end", 32'(bus.timeout_err), 32'd0);
    check("to_count", 32'(n_to), 32'd1);
    run_frame("or_after_to", 8'h0F, 8'hF0, 8'h25, 6'h25, 8'hFF, 0, 1'b0);

    // Byte B lands exactly on the last allowed cycle
    run_frame("b_on_edge", 8'h11, 8'h22, 8'h26, 6'h26, 8'h33, 14, 1'b0);
    check("b_on_edge_no_to", 32'(n_to), 32'd1);

    run_frame("ovr", 8'h07, 8'h01, 8'h22, 6'h22, 8'h06, 0, 1'b1);
    run_frame("and_after_ovr", 8'h0C, 8'h0A, 8'h24, 6'h24, 8'h08, 0, 1'b0);
    check("ovr_sticky", 32'(bus.rx_overrun), 32'd1);

    // Asynchronous reset while waiting for the opcode
    send_byte(8'h55);
    send_byte(8'h66);
    check("mid_dato_b", 32'(bus.dato_b), 32'h66);
    txs0 = n_txs;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_dato_a",  32'(bus.dato_a), 32'd0);
    check("mid_rst_dato_b",  32'(bus.dato_b), 32'd0);
    check("mid_rst_opcode",  32'(bus.opcode), 32'd0);
    check("mid_rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("mid_rst_busy",    32'(bus.busy), 32'd0);
    check("mid_rst_overrun", 32'(bus.rx_overrun), 32'd0);
    check("mid_rst_start",   32'(bus.tx_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_rst_no_start", 32'(n_txs - txs0), 32'd0);
    check("mid_rst_idle", 32'(bus.busy), 32'd0);
    run_frame("fresh", 8'h09, 8'h04, 8'h20, 6'h20, 8'h0D, 0, 1'b0);

    run_frame("mask_or", 8'h0F, 8'h33, 8'hE5, 6'h25, 8'h3F, 0, 1'b0);
    run_frame("mask_bad", 8'h01, 8'h02, 8'hFF, 6'h3F, 8'h00, 0, 1'b0);
    check("final_to_count", 32'(n_to), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
